// File: rtl/sprite_copy_engine.sv
// Sprite/background blitter: copies a 16x16 tile or a full 320x240 image from ROM
// into a VGA plotter, clipping off-screen pixels and skipping the transparent key colour.
module sprite_copy_engine #(
  parameter logic [2:0] KEY_COLOUR = 3'b101,
  parameter bit         KEY_EN     = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        go,
  input  logic        refresh,
  input  logic [8:0]  X,
  input  logic [7:0]  Y,
  input  logic [1:0]  memory_select,
  input  logic [3:0]  tile_select,
  output logic [11:0] tile_addr,
  input  logic [2:0]  tile_data,
  output logic [16:0] img_addr,
  output logic [1:0]  img_select,
  input  logic [2:0]  img_data,
  output logic [8:0]  X_out,
  output logic [7:0]  Y_out,
  output logic [2:0]  colour,
  output logic        write_en,
  output logic        finished
);

  typedef enum logic [1:0] {IDLE, DRAW, FLUSH, DONE} state_t;

  state_t      r_state;
  logic        r_refresh;
  logic [8:0]  r_xLat;
  logic [7:0]  r_yLat;
  logic [3:0]  r_tileLat;
  logic [1:0]  r_memSel;
  logic        r_finished;

  logic [8:0]  r_col;
  logic [7:0]  r_row;
  logic        r_countActive;

  logic        r_aValid;
  logic        r_aLast;
  logic [8:0]  r_aCol;
  logic [7:0]  r_aRow;
  logic [11:0] r_tileAddr;
  logic [16:0] r_imgAddr;

  logic        r_bValid;
  logic        r_bInRange;
  logic        r_bLast;
  logic [8:0]  r_xOut;
  logic [7:0]  r_yOut;

  logic        w_start;
  logic [8:0]  w_colMax;
  logic [7:0]  w_rowMax;
  logic        w_colWrap;
  logic        w_rowWrap;
  logic [16:0] w_rowTimes320;
  logic [9:0]  w_xSum;
  logic [8:0]  w_ySum;
  logic [8:0]  w_xPix;
  logic [7:0]  w_yPix;
  logic        w_overflow;
  logic        w_inRange;
  logic [2:0]  w_data;
  logic        w_keyed;

  assign w_start       = (r_state == IDLE) && go;
  assign w_colMax      = r_refresh ? 9'd319 : 9'd15;
  assign w_rowMax      = r_refresh ? 8'd239 : 8'd15;
  assign w_colWrap     = (r_col == w_colMax);
  assign w_rowWrap     = (r_row == w_rowMax);
  assign w_rowTimes320 = {1'b0, r_row, 8'd0} + {3'd0, r_row, 6'd0};

  // Extra carry bit on each sum so a tile hanging off the right/bottom edge is clipped, not wrapped.
  assign w_xSum     = {1'b0, r_xLat} + {1'b0, r_aCol};
  assign w_ySum     = {1'b0, r_yLat} + {1'b0, r_aRow};
  assign w_xPix     = r_refresh ? r_aCol : w_xSum[8:0];
  assign w_yPix     = r_refresh ? r_aRow : w_ySum[7:0];
  assign w_overflow = !r_refresh && (w_xSum[9] || w_ySum[8]);
  assign w_inRange  = !w_overflow && (w_xPix < 9'd320) && (w_yPix < 8'd240);

  assign w_data   = r_refresh ? img_data : tile_data;
  assign w_keyed  = !r_refresh && KEY_EN && (tile_data == KEY_COLOUR);

  assign tile_addr  = r_tileAddr;
  assign img_addr   = r_imgAddr;
  assign img_select = r_memSel;
  assign X_out      = r_xOut;
  assign Y_out      = r_yOut;
  assign colour     = r_bValid ? w_data : 3'd0;
  assign write_en   = r_bValid && r_bInRange && !w_keyed;
  assign finished   = r_finished;

  // Sequencer: latches the request, waits for the last pixel to leave the pipeline, then pulses finished.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_refresh  <= 1'b0;
      r_xLat     <= 9'd0;
      r_yLat     <= 8'd0;
      r_tileLat  <= 4'd0;
      r_memSel   <= 2'd0;
      r_finished <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_finished <= 1'b0;
          if (go) begin
            r_refresh <= refresh;
            r_xLat    <= X;
            r_yLat    <= Y;
            r_tileLat <= tile_select;
            r_memSel  <= memory_select;
            r_state   <= DRAW;
          end
        end
        DRAW: begin
          if (r_bLast) r_state <= FLUSH;
        end
        FLUSH: begin
          r_finished <= 1'b1;
          r_state    <= DONE;
        end
        DONE: begin
          r_finished <= 1'b0;
          r_state    <= IDLE;
        end
        default: begin
          r_finished <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

  // Raster counters feed an address stage, then an output stage aligned with the one-cycle ROM read.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_col         <= 9'd0;
      r_row         <= 8'd0;
      r_countActive <= 1'b0;
      r_aValid      <= 1'b0;
      r_aLast       <= 1'b0;
      r_aCol        <= 9'd0;
      r_aRow        <= 8'd0;
      r_tileAddr    <= 12'd0;
      r_imgAddr     <= 17'd0;
      r_bValid      <= 1'b0;
      r_bInRange    <= 1'b0;
      r_bLast       <= 1'b0;
      r_xOut        <= 9'd0;
      r_yOut        <= 8'd0;
    end else begin
      if (w_start) begin
        r_col         <= 9'd0;
        r_row         <= 8'd0;
        r_countActive <= 1'b1;
      end else if (r_countActive) begin
        if (w_colWrap) begin
          r_col <= 9'd0;
          if (w_rowWrap) r_countActive <= 1'b0;
          else           r_row         <= r_row + 8'd1;
        end else begin
          r_col <= r_col + 9'd1;
        end
      end

      r_aValid <= r_countActive;
      r_aLast  <= r_countActive && w_colWrap && w_rowWrap;
      r_aCol   <= r_col;
      r_aRow   <= r_row;
      if (r_countActive) begin
        r_tileAddr <= {r_tileLat, r_row[3:0], r_col[3:0]};
        r_imgAddr  <= w_rowTimes320 + {8'd0, r_col};
      end

      r_bValid   <= r_aValid;
      r_bInRange <= r_aValid && w_inRange;
      r_bLast    <= r_aLast;
      if (r_aValid) begin
        r_xOut <= w_xPix;
        r_yOut <= w_yPix;
      end
    end
  end

endmodule

// File: tb/tb_sprite_copy_engine.sv
// Randomised bench for sprite_copy_engine: behavioural raster model with ROM models,
// checking pixel stream, clipping, key colour, timing, back-to-back start and reset abort.
module tb_sprite_copy_engine;

  localparam int KEY = 5;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        go = 1'b0;
  logic        refresh = 1'b0;
  logic [8:0]  X = '0;
  logic [7:0]  Y = '0;
  logic [1:0]  memory_select = '0;
  logic [3:0]  tile_select = '0;
  logic [11:0] tile_addr;
  logic [2:0]  tile_data;
  logic [16:0] img_addr;
  logic [1:0]  img_select;
  logic [2:0]  img_data;
  logic [8:0]  X_out;
  logic [7:0]  Y_out;
  logic [2:0]  colour;
  logic        write_en;
  logic        finished;

  int checks = 0;
  int failures = 0;

  logic [2:0] tileRom [4096];

  typedef struct {
    int cyc;
    int x;
    int y;
    int c;
  } pix_t;

  sprite_copy_engine dut (
    .clock(clock), .reset(reset), .go(go), .refresh(refresh), .X(X), .Y(Y),
    .memory_select(memory_select), .tile_select(tile_select), .tile_addr(tile_addr),
    .tile_data(tile_data), .img_addr(img_addr), .img_select(img_select), .img_data(img_data),
    .X_out(X_out), .Y_out(Y_out), .colour(colour), .write_en(write_en), .finished(finished)
  );

  always #5 clock = ~clock;

  function automatic logic [2:0] imgPix(input int sel, input int a);
    return 3'((a * 7 + a / 97 + sel * 3) % 8);
  endfunction

  always_ff @(posedge clock) begin
    tile_data <= tileRom[tile_addr];
    img_data  <= imgPix(int'(img_select), int'(img_addr));
  end

  // Drives one copy and scores the observed write stream against a raster model of the request.
  // Cycle j means the values visible after the j-th rising edge following the edge that accepted go.
  task automatic runCopy(input bit isRefresh, input int xs, input int ys, input int tile,
                         input int mem, input bit holdGo, input int goPulseAt, input int abortAt,
                         output int nWrites, output int nBad, output int expCount,
                         output int finCount, output int finCycle, output int lastX,
                         output int lastY, output int lastCycle, output int lateFirst);
    pix_t expQ[$];
    pix_t e;
    int   w, h, n, limit;
    w = isRefresh ? 320 : 16;
    h = isRefresh ? 240 : 16;
    n = w * h;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        e.cyc = 2 + r * w + c;
        e.x   = isRefresh ? c : xs + c;
        e.y   = isRefresh ? r : ys + r;
        e.c   = isRefresh ? int'(imgPix(mem, r * 320 + c)) : int'(tileRom[tile * 256 + r * 16 + c]);
        if (e.x < 320 && e.y < 240 && !(!isRefresh && e.c == KEY)) expQ.push_back(e);
      end
    end
    expCount = expQ.size();
    nWrites = 0; nBad = 0; finCount = 0; finCycle = -1;
    lastX = -1; lastY = -1; lastCycle = -1; lateFirst = -1;
    limit = (abortAt > 0) ? abortAt : n + 10;

    @(negedge clock);
    go = 1'b1; refresh = isRefresh; X = 9'(xs); Y = 8'(ys);
    tile_select = 4'(tile); memory_select = 2'(mem);
    @(posedge clock);
    @(negedge clock);
    if (!holdGo) go = 1'b0;
    for (int j = 1; j <= limit; j++) begin
      @(posedge clock);
      @(negedge clock);
      if (j == goPulseAt) begin
        go = 1'b1; X = 9'(xs + 37); Y = 8'(ys + 11); tile_select = 4'(tile + 3);
        refresh = ~isRefresh; memory_select = 2'(mem + 1);
      end else if (j == goPulseAt + 1 && !holdGo) begin
        go = 1'b0;
      end
      if (finished) begin
        finCount++;
        finCycle = j;
      end
      if (write_en) begin
        if (j > n + 3) begin
          if (lateFirst < 0) lateFirst = j;
        end else begin
          nWrites++;
          lastX = int'(X_out); lastY = int'(Y_out); lastCycle = j;
          if (expQ.size() == 0) nBad++;
          else begin
            e = expQ.pop_front();
            if (e.cyc != j || e.x != int'(X_out) || e.y != int'(Y_out) || e.c != int'(colour))
              nBad++;
          end
        end
      end
    end
    if (abortAt == 0) nBad += expQ.size();
    go = 1'b0;
  endtask

  task automatic fillTile(input int tile, input bit randomFill, input int value);
    for (int i = 0; i < 256; i++)
      tileRom[tile * 256 + i] = randomFill ? 3'($urandom_range(0, 7)) : 3'(value);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    checks++;
    if (write_en !== 1'b0 || finished !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_strobes: write_en=%b finished=%b, required 0/0", write_en, finished);
    end
    checks++;
    if (X_out !== 9'd0 || Y_out !== 8'd0 || colour !== 3'd0) begin
      failures++;
      $display("[TB] FAIL reset_pixel: X_out=%0d Y_out=%0d colour=%0d, required 0", X_out, Y_out, colour);
    end
    checks++;
    if (tile_addr !== 12'd0 || img_addr !== 17'd0 || img_select !== 2'd0) begin
      failures++;
      $display("[TB] FAIL reset_addr: tile_addr=%0d img_addr=%0d img_select=%0d, required 0",
               tile_addr, img_addr, img_select);
    end
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_tile_basic();
    int nW, nB, ex, fc, fcy, lx, ly, lc, lf;
    fillTile(10, 1'b0, 2);
    runCopy(1'b0, 72, 32, 10, 0, 1'b0, -5, 0, nW, nB, ex, fc, fcy, lx, ly, lc, lf);
    checks++;
    if (nW != 256) begin failures++; $display("[TB] FAIL tile_count: got %0d writes, required 256", nW); end
    checks++;
    if (nB != 0) begin failures++; $display("[TB] FAIL tile_stream: %0d bad pixels, required 0", nB); end
    checks++;
    if (fc != 1 || fcy != 259) begin
      failures++; $display("[TB] FAIL tile_finish: %0d pulses at cycle %0d, required 1 at 259", fc, fcy);
    end
    checks++;
    if (lx != 87 || ly != 47 || lc != 257) begin
      failures++; $display("[TB] FAIL tile_last: (%0d,%0d) at %0d, required (87,47) at 257", lx, ly, lc);
    end
  endtask

  task automatic test_key_colour();
    int nW, nB, ex, fc, fcy, lx, ly, lc, lf;
    fillTile(10, 1'b0, 2);
    tileRom[10 * 256 + 3] = 3'(KEY);
    runCopy(1'b0, 72, 32, 10, 0, 1'b0, -5, 0, nW, nB, ex, fc, fcy, lx, ly, lc, lf);
    checks++;
    if (nW != 255 || nB != 0) begin
      failures++; $display("[TB] FAIL key_skip: %0d writes %0d bad, required 255 writes 0 bad", nW, nB);
    end
    checks++;
    if (fcy != 259) begin failures++; $display("[TB] FAIL key_finish: cycle %0d, required 259", fcy); end
  endtask

  task automatic test_clip();
    int nW, nB, ex, fc, fcy, lx, ly, lc, lf;
    fillTile(4, 1'b0, 6);
    runCopy(1'b0, 312, 232, 4, 0, 1'b0, -5, 0, nW, nB, ex, fc, fcy, lx, ly, lc, lf);
    checks++;
    if (nW != 64 || nB != 0) begin
      failures++; $display("[TB] FAIL clip_count: %0d writes %0d bad, required 64 writes 0 bad", nW, nB);
    end
    checks++;
    if (fc != 1 || fcy != 259) begin
      failures++; $display("[TB] FAIL clip_finish: %0d pulses at %0d, required 1 at 259", fc, fcy);
    end
  endtask

  task automatic test_random_tiles();
    int nW, nB, ex, fc, fcy, lx, ly, lc, lf, t;
    for (int i = 0; i < 6; i++) begin
      t = $urandom_range(0, 15);
      fillTile(t, 1'b1, 0);
      runCopy(1'b0, $urandom_range(0, 511), $urandom_range(0, 255), t, $urandom_range(0, 3),
              1'b0, -5, 0, nW, nB, ex, fc, fcy, lx, ly, lc, lf);
      checks++;
      if (nW != ex || nB != 0 || fcy != 259) begin
        failures++;
        $display("[TB] FAIL random_tile_%0d: %0d writes %0d bad fin@%0d, required %0d writes 0 bad fin@259",
                 i, nW, nB, fcy, ex);
      end
    end
  endtask

  task automatic test_back_to_back();
    int nW, nB, ex, fc, fcy, lx, ly, lc, lf, seen;
    fillTile(7, 1'b0, 1);
    runCopy(1'b0, 100, 100, 7, 0, 1'b1, -5, 0, nW, nB, ex, fc, fcy, lx, ly, lc, lf);
    checks++;
    if (nB != 0 || fc != 1 || fcy != 259) begin
      failures++; $display("[TB] FAIL b2b_first: %0d bad, %0d pulses at %0d, required 0 bad, 1 at 259", nB, fc, fcy);
    end
    checks++;
    if (lf != 263) begin failures++; $display("[TB] FAIL b2b_restart: first write at %0d, required 263", lf); end
    seen = 0;
    for (int j = 0; j < 400 && seen == 0; j++) begin
      @(negedge clock);
      if (finished) seen = 1;
    end
    checks++;
    if (seen != 1) begin failures++; $display("[TB] FAIL b2b_second_finish: seen=%0d, required 1", seen); end
    repeat (3) @(negedge clock);
  endtask

  task automatic test_abort();
    int nW, nB, ex, fc, fcy, lx, ly, lc, lf, wCount;
    for (int i = 0; i < 256; i++) tileRom[3 * 256 + i] = 3'($urandom_range(0, 4));
    runCopy(1'b0, 20, 40, 3, 1, 1'b0, 50, 102, nW, nB, ex, fc, fcy, lx, ly, lc, lf);
    checks++;
    if (nW != 101 || nB != 0 || fc != 0) begin
      failures++;
      $display("[TB] FAIL abort_prefix: %0d writes %0d bad %0d pulses, required 101 writes 0 bad 0 pulses", nW, nB, fc);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (write_en !== 1'b0 || X_out !== 9'd0 || Y_out !== 8'd0 || colour !== 3'd0 || finished !== 1'b0) begin
      failures++;
      $display("[TB] FAIL abort_outputs: we=%b X=%0d Y=%0d c=%0d fin=%b, required all 0",
               write_en, X_out, Y_out, colour, finished);
    end
    checks++;
    if (tile_addr !== 12'd0 || img_addr !== 17'd0) begin
      failures++; $display("[TB] FAIL abort_addr: tile_addr=%0d img_addr=%0d, required 0", tile_addr, img_addr);
    end
    @(negedge clock);
    reset = 1'b0;
    fc = 0; wCount = 0;
    for (int j = 0; j < 300; j++) begin
      @(negedge clock);
      if (finished) fc++;
      if (write_en) wCount++;
    end
    checks++;
    if (fc != 0 || wCount != 0) begin
      failures++; $display("[TB] FAIL abort_quiet: %0d pulses %0d writes, required 0/0", fc, wCount);
    end
    runCopy(1'b0, 20, 40, 3, 1, 1'b0, -5, 0, nW, nB, ex, fc, fcy, lx, ly, lc, lf);
    checks++;
    if (nW != ex || nB != 0 || fcy != 259) begin
      failures++; $display("[TB] FAIL abort_restart: %0d writes %0d bad fin@%0d, required %0d 0 259", nW, nB, fcy, ex);
    end
  endtask

  task automatic test_screen();
    int nW, nB, ex, fc, fcy, lx, ly, lc, lf;
    runCopy(1'b1, 0, 0, 0, 2, 1'b0, -5, 0, nW, nB, ex, fc, fcy, lx, ly, lc, lf);
    checks++;
    if (img_select !== 2'd2) begin failures++; $display("[TB] FAIL screen_select: %0d, required 2", img_select); end
    checks++;
    if (nW != 76800 || nB != 0) begin
      failures++; $display("[TB] FAIL screen_stream: %0d writes %0d bad, required 76800 writes 0 bad", nW, nB);
    end
    checks++;
    if (lx != 319 || ly != 239 || lc != 76801) begin
      failures++; $display("[TB] FAIL screen_last: (%0d,%0d) at %0d, required (319,239) at 76801", lx, ly, lc);
    end
    checks++;
    if (fc != 1 || fcy != 76803) begin
      failures++; $display("[TB] FAIL screen_finish: %0d pulses at %0d, required 1 at 76803", fc, fcy);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) tileRom[i] = 3'd0;
    test_reset();
    test_tile_basic();
    test_key_colour();
    test_clip();
    test_random_tiles();
    test_back_to_back();
    test_abort();
    test_screen();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sprite_copy_engine.md
SPRITE_COPY_ENGINE -- requirements
Module: sprite_copy_engine

Interface
REQ-001 SHALL have parameter KEY_COLOUR, default 3'b101, tile pixel value treated as transparent.
REQ-002 SHALL have parameter KEY_EN, default 1, 1 = suppress writes of KEY_COLOUR pixels in tile copies.
REQ-003 SHALL have port clock, input, 1, system clock (50 MHz); all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high.
REQ-005 SHALL have port go, input, 1, start request, sampled only in IDLE.
REQ-006 SHALL have port refresh, input, 1, sampled with go; 1 = full-screen copy, 0 = 16x16 tile copy.
REQ-007 SHALL have port X, input, 9, tile top-left column, latched at start.
REQ-008 SHALL have port Y, input, 8, tile top-left row, latched at start.
REQ-009 SHALL have port memory_select, input, 2, full-screen image: 0 stage, 1 title, 2 P1 win, 3 P2 win.
REQ-010 SHALL have port tile_select, input, 4, tile ROM index 0-15, latched at start.
REQ-011 SHALL have port tile_addr, output, 12, tile ROM address {tile, row[3:0], col[3:0]}.
REQ-012 SHALL have port tile_data, input, 3, tile ROM data, valid one cycle after tile_addr.
REQ-013 SHALL have port img_addr, output, 17, image ROM address row*320+col.
REQ-014 SHALL have port img_select, output, 2, latched memory_select.
REQ-015 SHALL have port img_data, input, 3, image ROM data, valid one cycle after img_addr.
REQ-016 SHALL have port X_out, output, 9, VGA pixel column.
REQ-017 SHALL have port Y_out, output, 8, VGA pixel row.
REQ-018 SHALL have port colour, output, 3, VGA pixel colour.
REQ-019 SHALL have port write_en, output, 1, VGA plot strobe.
REQ-020 SHALL have port finished, output, 1, one-cycle completion pulse.

Function
REQ-021 FSM SHALL have states IDLE, DRAW, FLUSH, DONE.
REQ-022 IDLE + go=1 at edge k SHALL latch X, Y, tile_select, memory_select, refresh; zero col/row counters; enter DRAW.
REQ-023 DRAW SHALL issue one address per cycle, col fastest; tile wraps col at 15, full-screen at 319, row increments on wrap.
REQ-024 Address of last pixel (tile 15,15; screen 319,239) SHALL move to FLUSH next cycle.
REQ-025 FLUSH SHALL last one cycle (final ROM read), then DONE; DONE SHALL assert finished for one cycle, then IDLE.
REQ-026 Pixel issued at cycle n SHALL appear on X_out/Y_out/colour/write_en at cycle n+1 (1-stage coordinate pipeline matching ROM latency).
REQ-027 Tile mode: X_out = X_lat + col (9-bit), Y_out = Y_lat + row (8-bit), colour = tile_data.
REQ-028 Screen mode: X_out = col, Y_out = row, colour = img_data; KEY_COLOUR not applied.
REQ-029 write_en SHALL be 0 when X_out >= 320, Y_out >= 240, or 9/8-bit sum overflowed (clip, no wrap).
REQ-030 write_en SHALL be 0 in tile mode when KEY_EN=1 and tile_data == KEY_COLOUR; coordinates still advance.
REQ-031 write_en SHALL be 0 in IDLE and DONE; finished SHALL be 0 outside DONE.
REQ-032 go asserted outside IDLE SHALL be ignored and not queued; latched inputs SHALL not change mid-copy.
REQ-033 go held high through DONE SHALL start a new copy on the edge after returning to IDLE (no back-to-back re-entry from DONE).
REQ-034 Latency: tile go at edge k -> write_en cycles k+2..k+257, finished at k+259; screen -> 76800 pixel cycles, finished at k+76803.

Reset
REQ-035 reset SHALL asynchronously force IDLE, counters 0, latched registers 0, X_out 0, Y_out 0, colour 0, write_en 0, finished 0, tile_addr 0, img_addr 0.
REQ-036 reset mid-copy SHALL abort without finished pulse; next go after release SHALL start a clean copy.

Verification
REQ-037 Tile go, X=72, Y=32, tile_select=10, ROM all 3'b010 -> 256 writes covering (72..87, 32..47) raster order, finished once at k+259.
REQ-038 Tile ROM pixel (row 0, col 3) = 3'b101, KEY_EN=1 -> no write at (75,32), other 255 pixels written, timing unchanged.
REQ-039 Tile at X=312, Y=232 -> writes only cols 312..319, rows 232..239 (64 pixels), finished still at k+259.
REQ-040 refresh=1, memory_select=2 -> img_select=2, 76800 writes, last at (319,239), finished at k+76803.
REQ-041 go pulsed mid-copy, then reset asserted at pixel 100 -> second go ignored, outputs 0 immediately, no finished pulse.
